// File: rtl/frame_send.sv
// frame_send: transmit-side framer feeding the serializer with 16-bit words.
// After reset or CLR it sends TRAIN_LEN training words with PHY_INIT high.
// It then sends continuous frames: SYNC, sequence number, PRBS15 payload and
// an XOR checksum. Output words are paced by a downstream pull handshake.
//
// Ports:
//   CLK        word clock
//   RSTX       asynchronous active-low reset
//   CLR        synchronous restart to training (wins over a consume)
//   EN         frame enable, only looked at on frame boundaries
//   DOPULL     consumer takes DOUT this cycle
//   PHY_INIT   high while training
//   DOUT       output word, DOUT[15] goes out first
//   DOPUSH     DOUT valid (high from the first clock after reset)
//   FRAME_CNT  number of completed frames (wraps)
module frame_send #(
  parameter int unsigned TRAIN_LEN   = 1024,
  parameter logic [15:0] TRAIN_WORD  = 16'hFF00,
  parameter logic [15:0] SYNC_WORD   = 16'hF628,
  parameter logic [15:0] IDLE_WORD   = 16'hAAAA,
  parameter int unsigned PAYLOAD_LEN = 64
) (
  input  logic        CLK,
  input  logic        RSTX,
  input  logic        CLR,
  input  logic        EN,
  input  logic        DOPULL,
  output logic        PHY_INIT,
  output logic [15:0] DOUT,
  output logic        DOPUSH,
  output logic [31:0] FRAME_CNT
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned PRBS_W = 15;
  localparam int unsigned FCNT_W = 32;
  localparam int unsigned TCNT_W = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
  localparam logic [PRBS_W-1:0] PRBS_SEED = 15'h7FFF;
  localparam logic [TCNT_W-1:0] TRAIN_LAST = TCNT_W'(TRAIN_LEN - 1);
  localparam logic [WORD_W-1:0] PAY_LAST = WORD_W'(PAYLOAD_LEN - 1);

  typedef enum logic [2:0] {
    ST_TRAIN,
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_PAY,
    ST_CSUM
  } state_t;

  state_t              state, state_nxt;
  logic [TCNT_W-1:0]   train_cnt, train_cnt_nxt;
  logic [WORD_W-1:0]   seq, seq_nxt;
  logic [WORD_W-1:0]   csum, csum_nxt;
  logic [WORD_W-1:0]   pay_cnt, pay_cnt_nxt;
  logic [PRBS_W-1:0]   prbs, prbs_nxt;
  logic [FCNT_W-1:0]   frame_cnt_nxt;
  logic [WORD_W-1:0]   dout_nxt;
  logic                phy_init_nxt;
  logic                consume;

  // PRBS15 (x^15+x^14+1) state after 16 steps
  function automatic logic [PRBS_W-1:0] prbs_next(input logic [PRBS_W-1:0] s_in);
    logic [PRBS_W-1:0] s;
    s = s_in;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      s = {s[PRBS_W-2:0], s[PRBS_W-1] ^ s[PRBS_W-2]};
    end
    return s;
  endfunction

  // The 16 feedback bits produced from state s_in, first bit in the MSB
  function automatic logic [WORD_W-1:0] prbs_word(input logic [PRBS_W-1:0] s_in);
    logic [PRBS_W-1:0] s;
    logic [WORD_W-1:0] w;
    s = s_in;
    w = '0;
    for (int unsigned i = 0; i < WORD_W; i++) begin
      w = {w[WORD_W-2:0], s[PRBS_W-1] ^ s[PRBS_W-2]};
      s = {s[PRBS_W-2:0], s[PRBS_W-1] ^ s[PRBS_W-2]};
    end
    return w;
  endfunction

  assign consume = DOPUSH & DOPULL;

  // Next-state and next-output logic; everything holds unless a word is consumed
  always_comb begin
    state_nxt     = state;
    train_cnt_nxt = train_cnt;
    seq_nxt       = seq;
    csum_nxt      = csum;
    pay_cnt_nxt   = pay_cnt;
    prbs_nxt      = prbs;
    frame_cnt_nxt = FRAME_CNT;
    phy_init_nxt  = PHY_INIT;
    dout_nxt      = DOUT;

    if (CLR) begin
      state_nxt     = ST_TRAIN;
      train_cnt_nxt = '0;
      seq_nxt       = '0;
      csum_nxt      = '0;
      pay_cnt_nxt   = '0;
      prbs_nxt      = PRBS_SEED;
      frame_cnt_nxt = '0;
      phy_init_nxt  = 1'b1;
      dout_nxt      = TRAIN_WORD;
    end else if (consume) begin
      unique case (state)
        ST_TRAIN: begin
          if (train_cnt == TRAIN_LAST) begin
            phy_init_nxt = 1'b0;
            state_nxt    = EN ? ST_SYNC : ST_IDLE;
          end else begin
            train_cnt_nxt = train_cnt + TCNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (EN) state_nxt = ST_SYNC;
        end
        ST_SYNC: state_nxt = ST_SEQ;
        ST_SEQ: begin
          csum_nxt    = seq;
          pay_cnt_nxt = '0;
          state_nxt   = ST_PAY;
        end
        ST_PAY: begin
          // DOUT holds the payload word being consumed
          prbs_nxt = prbs_next(prbs);
          csum_nxt = csum ^ DOUT;
          if (pay_cnt == PAY_LAST) begin
            state_nxt = ST_CSUM;
          end else begin
            pay_cnt_nxt = pay_cnt + WORD_W'(1);
          end
        end
        ST_CSUM: begin
          frame_cnt_nxt = FRAME_CNT + FCNT_W'(1);
          seq_nxt       = seq + WORD_W'(1);
          state_nxt     = EN ? ST_SYNC : ST_IDLE;
        end
        default: state_nxt = ST_TRAIN;
      endcase

      // Word presented for the state being entered
      unique case (state_nxt)
        ST_TRAIN: dout_nxt = TRAIN_WORD;
        ST_IDLE:  dout_nxt = IDLE_WORD;
        ST_SYNC:  dout_nxt = SYNC_WORD;
        ST_SEQ:   dout_nxt = seq_nxt;
        ST_PAY:   dout_nxt = prbs_word(prbs_nxt);
        ST_CSUM:  dout_nxt = csum_nxt;
        default:  dout_nxt = TRAIN_WORD;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state     <= ST_TRAIN;
      train_cnt <= '0;
      seq       <= '0;
      csum      <= '0;
      pay_cnt   <= '0;
      prbs      <= PRBS_SEED;
      FRAME_CNT <= '0;
      PHY_INIT  <= 1'b1;
      DOUT      <= TRAIN_WORD;
      DOPUSH    <= 1'b0;
    end else begin
      state     <= state_nxt;
      train_cnt <= train_cnt_nxt;
      seq       <= seq_nxt;
      csum      <= csum_nxt;
      pay_cnt   <= pay_cnt_nxt;
      prbs      <= prbs_nxt;
      FRAME_CNT <= frame_cnt_nxt;
      PHY_INIT  <= phy_init_nxt;
      DOUT      <= dout_nxt;
      DOPUSH    <= 1'b1;
    end
  end

endmodule
